// File: rtl/fft_bin_server.sv
// fft_bin_server
//   Captures one complete FFT output frame into on-chip RAM and presents it
//   one bin at a time to a polling Nios processor. Software advances through
//   the bins by flipping ack_toggle. This decouples the FFT streaming rate
//   from the software polling rate.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   in_valid/in_sop/in_eop  FFT source stream framing
//   in_real/in_imag         FFT bin components (signed, DATA_W)
//   in_ready                always 1; frames that cannot be taken are dropped
//   ack_toggle              Nios handshake; each level change requests next bin
//   out_start               frame available / serving (to Nios fft_start)
//   out_cnt                 index of the presented bin (to Nios fft_cnt)
//   out_real/out_imag       presented bin data (to Nios fft_real / fft_img)
//   drop_cnt                saturating count of frames discarded since reset
module fft_bin_server #(
  parameter int N_BINS    = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 24,
  parameter int KEEP_BINS = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              in_ready,
  input  logic              ack_toggle,
  output logic              out_start,
  output logic [ADDR_W-1:0] out_cnt,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [7:0]        drop_cnt
);

  localparam int KEEP_W = (KEEP_BINS > 1) ? $clog2(KEEP_BINS) : 1;
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_BINS - 1);
  localparam logic [ADDR_W-1:0] LAST_KEEP = ADDR_W'(KEEP_BINS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, LOAD, SERVE} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state, state_d;
  logic [ADDR_W-1:0]   wr_idx, wr_idx_d;
  logic [ADDR_W-1:0]   rd_idx, rd_idx_d;
  logic                vld_p1, vld_p1_d;
  logic                ack_hist;
  logic                ack_seen;
  logic                drop_inc;
  logic                wr_en;
  logic [KEEP_W-1:0]   wr_addr;
  logic                out_load;
  logic                out_clear;

  logic [2*DATA_W-1:0] mem [KEEP_BINS];
  logic [2*DATA_W-1:0] rd_data_p1;

  assign in_ready = 1'b1;
  assign ack_seen = (ack_toggle != ack_hist);

  always_comb begin
    state_d   = state;
    wr_idx_d  = wr_idx;
    rd_idx_d  = rd_idx;
    vld_p1_d  = 1'b0;
    drop_inc  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wr_idx[KEEP_W-1:0];
    out_load  = 1'b0;
    out_clear = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_sop) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_idx_d = ADDR_W'(1);
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          if (in_sop) begin
            // Restart: the interrupted frame is lost, this beat is bin 0.
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_idx_d = ADDR_W'(1);
            drop_inc = 1'b1;
          end else begin
            wr_en    = (wr_idx <= LAST_KEEP);
            wr_idx_d = wr_idx + ADDR_W'(1);
            if (in_eop && wr_idx == LAST_BIN) begin
              rd_idx_d = '0;
              state_d  = LOAD;
            end else if (in_eop || wr_idx == LAST_BIN) begin
              // Early eop, or the last bin passed without eop.
              drop_inc = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      LOAD: begin
        drop_inc = in_valid && in_sop;
        // The RAM reads rd_idx every cycle; the first LOAD cycle sees stale
        // data, the second sees the word for the current rd_idx.
        if (!vld_p1) begin
          vld_p1_d = 1'b1;
        end else begin
          out_load = 1'b1;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        drop_inc = in_valid && in_sop;
        if (ack_seen) begin
          if (rd_idx == LAST_KEEP) begin
            out_clear = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_idx_d = rd_idx + ADDR_W'(1);
            state_d  = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      vld_p1    <= 1'b0;
      ack_hist  <= ack_toggle;
      drop_cnt  <= '0;
      out_start <= 1'b0;
      out_cnt   <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      wr_idx   <= wr_idx_d;
      rd_idx   <= rd_idx_d;
      vld_p1   <= vld_p1_d;
      // History follows the pin every cycle, so toggles outside SERVE are absorbed.
      ack_hist <= ack_toggle;
      if (drop_inc) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
      if (out_load) begin
        out_start <= 1'b1;
        out_cnt   <= rd_idx;
        out_real  <= rd_data_p1[2*DATA_W-1:DATA_W];
        out_imag  <= rd_data_p1[DATA_W-1:0];
      end else if (out_clear) begin
        out_start <= 1'b0;
        out_cnt   <= '0;
      end
    end
  end

  // Stage p0 -> p1: RAM write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {in_real, in_imag};
    end
    rd_data_p1 <= mem[rd_idx[KEEP_W-1:0]];
  end

endmodule

// File: doc/fft_bin_server.md
Name: fft_bin_server

Overview:
- Sits directly upstream of the Nios system, between the streaming FFT core and the Nios PIO inputs fft_real, fft_img, fft_start and fft_cnt.
- Captures one complete FFT output frame into on-chip RAM, then presents it one bin at a time to the polling Nios processor.
- Nios advances through the bins with a toggle handshake.
- Decouples the FFT streaming rate from the software polling rate.

Parameters:
- N_BINS, 1024, FFT frame length in bins (power of 2).
- ADDR_W, 10, log2(N_BINS); also the width of out_cnt.
- DATA_W, 24, signed width of the real and imag components.
- KEEP_BINS, 512, number of bins stored and served (bins 0..KEEP_BINS-1); must be ≤ N_BINS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  FFT source valid
- in_sop  in  1  FFT start of packet (bin 0)
- in_eop  in  1  FFT end of packet (bin N_BINS-1)
- in_real  in  DATA_W  FFT real output, signed
- in_imag  in  DATA_W  FFT imaginary output, signed
- in_ready  out  1  ready to FFT source
- ack_toggle  in  1  Nios handshake bit; each level change requests the next bin
- out_start  out  1  frame available / serving; drives the Nios fft_start input
- out_cnt  out  ADDR_W  index of the bin currently presented; drives fft_cnt
- out_real  out  DATA_W  real part of bin out_cnt; drives fft_real
- out_imag  out  DATA_W  imag part of bin out_cnt; drives fft_img
- drop_cnt  out  8  saturating count of frames discarded since reset

Behaviour:
- Reset: one clock and one synchronous active-high reset; reset is sampled only on the clk edge.
- Reset values:
  - state = IDLE, in_ready = 1, out_start = 0, out_cnt = 0, out_real = 0, out_imag = 0, drop_cnt = 0.
  - The ack_toggle history register loads the current ack_toggle, so no spurious ack is seen.
  - Reset mid-capture or mid-serve aborts immediately; RAM contents are don't-care.
- Storage: simple dual-port RAM, KEEP_BINS x 2*DATA_W, registered read (1-cycle read latency).
- in_ready is constantly 1; the block never backpressures. Frames that cannot be accepted are dropped.
- A beat is a cycle with in_valid = 1.
- States:
  - IDLE:
    - A beat with in_sop = 1 writes RAM[0], sets wr_idx = 1 and moves to CAPTURE.
    - Beats without sop are ignored.
  - CAPTURE:
    - Each beat writes RAM[wr_idx] when wr_idx < KEEP_BINS; beats beyond that are counted but not stored. wr_idx increments per beat.
    - Beat with in_sop = 1: restart the frame at bin 0 and increment drop_cnt.
    - Beat with in_eop = 1 and wr_idx == N_BINS-1: frame complete. Go to LOAD with rd_idx = 0.
    - Beat with in_eop = 1 and wr_idx != N_BINS-1: malformed frame. Increment drop_cnt and go to IDLE.
    - wr_idx reaching N_BINS without eop: increment drop_cnt and go to IDLE.
  - LOAD:
    - Issue RAM read of rd_idx.
    - Two cycles later, register out_real, out_imag and out_cnt = rd_idx together, assert out_start = 1, and go to SERVE.
    - out_cnt never changes before the matching data; the Nios polls fft_cnt to detect new data.
  - SERVE:
    - Hold outputs.
    - Sample ack_toggle each cycle; a difference from the history register is an ack, and the history is updated.
    - Ack with rd_idx < KEEP_BINS-1: rd_idx++, go to LOAD; out_start stays 1.
    - Ack with rd_idx == KEEP_BINS-1: out_start = 0, out_cnt = 0, go to IDLE.
    - Further acks while in LOAD are ignored. Software must wait for out_cnt to change before toggling again.
- FFT beats arriving in LOAD or SERVE are dropped. drop_cnt increments once per dropped sop.
- drop_cnt saturates at 255.
- Data passes through unmodified (no scaling); sign is preserved.

Test Plan:
- Reset, then one full 1024-beat frame with real = bin index and imag = -(bin index). Toggle ack 512 times, waiting for out_cnt each time → out_cnt steps 0..511; out_real = k, out_imag = -k at each step; out_start drops after the 512th ack.
- eop asserted on beat 700 → drop_cnt = 1, out_start stays 0. A following good frame is served normally.
- sop reasserted at beat 300 of a capture, then 1024 clean beats → drop_cnt = 1; the served data matches the second frame.
- New frame streamed while serving bin 10 → drop_cnt increments; served values are unchanged (bin 10 still shows the first frame's data).
- Two ack toggles one cycle apart in SERVE → only one advance (out_cnt 0 → 1); the second toggle is absorbed into the history register.
- reset asserted during SERVE at bin 200 → next cycle out_start = 0, out_cnt = 0, out_real = out_imag = 0. A subsequent frame is captured from IDLE.
